// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DEF_CLK_DIV = 434;

  // ones_odd is the XOR-reduction of the data word
  function automatic logic par_bit(input logic ones_odd,
                                   input int   mode);
    return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO; pointers carry one extra wrap bit for full/empty.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         push_ok;
  logic         pop_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = wr_q - rd_q;
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_ok) wr_d = wr_q + (AW+1)'(1);
    if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter; define UART_TX_FIFO_EN to add a TX FIFO
// (otherwise a single holding register and TX_FULL = TX_BUSY).
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 TX_START,
  input  logic [DATA_BITS-1:0] TX_DATA,
  output logic                 TX_BUSY,
  output logic                 TX_FULL,
  output logic                 TX_PIN
);

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [3:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   pin_q, pin_d;

  logic [DATA_BITS-1:0]   head;
  logic                   head_v;
  logic                   more;
  logic                   push;
  logic                   pop;
  logic                   cnt_end;
  logic                   par_w;

  assign push = TX_START & ~TX_FULL;

`ifdef UART_TX_FIFO_EN
  logic [$clog2(FIFO_DEPTH):0] f_cnt;
  logic                        f_empty;
  logic                        f_full;

  // Head stays queued until its frame ends, so it counts toward occupancy
  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_BITS)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (TX_DATA),
    .rdata_o (head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_cnt)
  );

  assign head_v  = ~f_empty;
  assign more    = f_cnt > ($clog2(FIFO_DEPTH)+1)'(1);
  assign TX_FULL = f_full;
  assign TX_BUSY = (state_q != ST_IDLE) | ~f_empty;
`else
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_v_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
    end else if (push) begin
      hold_q   <= TX_DATA;
      hold_v_q <= 1'b1;
    end else if (pop) begin
      hold_v_q <= 1'b0;
    end
  end

  assign head    = hold_q;
  assign head_v  = hold_v_q;
  assign more    = 1'b0;
  assign TX_BUSY = hold_v_q | (state_q != ST_IDLE);
  assign TX_FULL = TX_BUSY;
`endif

  assign cnt_end = (cnt_q == 16'(CLK_DIV-1));
  assign par_w   = par_bit(^head, PARITY);
  assign TX_PIN  = pin_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_end ? '0 : cnt_q + 16'd1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    pin_d   = pin_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        pin_d = 1'b1;
        if (head_v) begin
          state_d = ST_START;
          pin_d   = 1'b0;
        end
      end
      ST_START: begin
        if (cnt_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          pin_d   = head[0];
          sh_d    = head >> 1;
        end
      end
      ST_DATA: begin
        if (cnt_end) begin
          if (bit_q == 4'(DATA_BITS-1)) begin
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              pin_d   = par_w;
            end else begin
              state_d = ST_STOP;
              pin_d   = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
            pin_d = sh_q[0];
            sh_d  = sh_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (cnt_end) begin
          state_d = ST_STOP;
          pin_d   = 1'b1;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (cnt_end) begin
          if (stop_q == 1'(STOP_BITS-1)) begin
            pop = 1'b1;
            // Back-to-back only when a word beyond the current head waits
            if (more) begin
              state_d = ST_START;
              pin_d   = 1'b0;
            end else begin
              state_d = ST_IDLE;
              pin_d   = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pin_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      pin_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      pin_q   <= pin_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: vector table, random frames vs. a frame model,
// and hand sequences for reset, overrun and FIFO back-to-back behaviour.
module tb_uart_tx_param;

  logic       clk;
  logic       rst;
  logic [4:0] start_v;
  logic [4:0] busy_v;
  logic [4:0] full_v;
  logic [4:0] pin_v;
  logic [7:0] data_a [5];

  int checks = 0;
  int errors = 0;

  int DIV [5] = '{4, 4, 4, 4, 434};
  int NB  [5] = '{8, 8, 8, 8, 5};
  int PM  [5] = '{0, 1, 2, 0, 0};
  int SB  [5] = '{1, 1, 1, 2, 1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1)) u0 (
    .CLK(clk), .RST(rst), .TX_START(start_v[0]),
    .TX_DATA(data_a[0]), .TX_BUSY(busy_v[0]),
    .TX_FULL(full_v[0]), .TX_PIN(pin_v[0]));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(1),
                  .STOP_BITS(1)) u1 (
    .CLK(clk), .RST(rst), .TX_START(start_v[1]),
    .TX_DATA(data_a[1]), .TX_BUSY(busy_v[1]),
    .TX_FULL(full_v[1]), .TX_PIN(pin_v[1]));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1)) u2 (
    .CLK(clk), .RST(rst), .TX_START(start_v[2]),
    .TX_DATA(data_a[2]), .TX_BUSY(busy_v[2]),
    .TX_FULL(full_v[2]), .TX_PIN(pin_v[2]));

  uart_tx_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(2)) u3 (
    .CLK(clk), .RST(rst), .TX_START(start_v[3]),
    .TX_DATA(data_a[3]), .TX_BUSY(busy_v[3]),
    .TX_FULL(full_v[3]), .TX_PIN(pin_v[3]));

  uart_tx_param #(.CLK_DIV(434), .DATA_BITS(5), .PARITY(0),
                  .STOP_BITS(1)) u4 (
    .CLK(clk), .RST(rst), .TX_START(start_v[4]),
    .TX_DATA(data_a[4][4:0]), .TX_BUSY(busy_v[4]),
    .TX_FULL(full_v[4]), .TX_PIN(pin_v[4]));

  typedef struct {
    int         idx;
    logic [7:0] d;
    logic [11:0] exp;
    int         nb;
  } vec_t;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Line levels in transmit order, built straight from the frame rules
  function automatic logic [11:0] model_frame(input int idx,
                                              input logic [7:0] d,
                                              output int nb);
    logic [11:0] f;
    int pos;
    int ones;
    f    = '1;
    pos  = 0;
    ones = 0;
    f[pos] = 1'b0;
    pos++;
    for (int i = 0; i < NB[idx]; i++) begin
      f[pos] = d[i];
      ones += int'(d[i]);
      pos++;
    end
    if (PM[idx] == 1) begin
      f[pos] = (ones % 2 == 0);
      pos++;
    end else if (PM[idx] == 2) begin
      f[pos] = (ones % 2 == 1);
      pos++;
    end
    pos += SB[idx];
    nb = pos;
    return f;
  endfunction

  task automatic run_frame(input int idx, input logic [7:0] d,
                           input logic [11:0] exp, input int nb);
    int bad;
    @(negedge clk);
    data_a[idx]  = d;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    data_a[idx]  = ~d;
    chk($sformatf("u%0d %02h busy after accept", idx, d),
        int'(busy_v[idx]), 1);
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int c = 0; c < DIV[idx]; c++) begin
        @(negedge clk);
        if (pin_v[idx] !== exp[b] || busy_v[idx] !== 1'b1) bad++;
      end
      chk($sformatf("u%0d %02h bit%0d bad cycles", idx, d, b), bad, 0);
    end
    @(negedge clk);
    chk($sformatf("u%0d %02h idle pin,busy", idx, d),
        int'({pin_v[idx], busy_v[idx]}), 2);
  endtask

  initial begin
    vec_t        tbl [6];
    int          idx;
    int          nb;
    int          bad;
    logic [7:0]  d;
    logic [11:0] exp;
    logic [11:0] fr [4];

    tbl[0] = '{0, 8'h55, 12'h2AA, 10};
    tbl[1] = '{1, 8'h07, 12'h40E, 11};
    tbl[2] = '{2, 8'h07, 12'h60E, 11};
    tbl[3] = '{3, 8'h07, 12'h60E, 11};
    tbl[4] = '{4, 8'h1F, 12'h07E, 7};
    tbl[5] = '{0, 8'hA3, 12'h346, 10};

    rst     = 1'b1;
    start_v = '0;
    for (int i = 0; i < 5; i++) data_a[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset u%0d pin", i), int'(pin_v[i]), 1);
      chk($sformatf("reset u%0d busy", i), int'(busy_v[i]), 0);
      chk($sformatf("reset u%0d full", i), int'(full_v[i]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_frame(tbl[v].idx, tbl[v].d, tbl[v].exp, tbl[v].nb);

    for (int r = 0; r < 16; r++) begin
      idx = int'($urandom_range(0, 3));
      d   = 8'($urandom);
      exp = model_frame(idx, d, nb);
      run_frame(idx, d, exp, nb);
    end

    // Mid-frame reset: line must return high without waiting for a clock
    @(negedge clk);
    data_a[0]  = 8'h55;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async reset pin", int'(pin_v[0]), 1);
    chk("async reset busy", int'(busy_v[0]), 0);
    chk("async reset full", int'(full_v[0]), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("after reset queue empty", int'({pin_v[0], busy_v[0]}), 2);
    run_frame(0, 8'hA3, 12'h346, 10);

`ifdef UART_TX_FIFO_EN
    for (int j = 0; j < 4; j++) fr[j] = model_frame(0, 8'(j + 1), nb);
    @(negedge clk);
    data_a[0]  = 8'h01;
    start_v[0] = 1'b1;
    bad = 0;
    for (int j = 1; j <= 162; j++) begin
      int k;
      @(negedge clk);
      k = j - 1;
      if (j == 4) chk("fifo full after 4th write", int'(full_v[0]), 1);
      if (j <= 4) begin
        data_a[0] = 8'(j + 1);
      end else begin
        start_v[0] = 1'b0;
        data_a[0]  = 8'hFF;
      end
      if (k >= 1 && k <= 160) begin
        if (pin_v[0] !== fr[(k - 1) / 40][((k - 1) % 40) / 4] ||
            busy_v[0] !== 1'b1) bad++;
        if (k % 40 == 0) begin
          chk($sformatf("fifo frame%0d bad cycles", k / 40 - 1), bad, 0);
          bad = 0;
        end
      end
      if (k == 161)
        chk("fifo drained, 5th dropped", int'({pin_v[0], busy_v[0]}), 2);
    end
`else
    @(negedge clk);
    data_a[0]  = 8'h55;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    data_a[0]  = 8'h00;
    exp = 12'h2AA;
    bad = 0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (k == 10) begin
        chk("full during frame", int'(full_v[0]), 1);
        start_v[0] = 1'b1;
        data_a[0]  = 8'hFF;
      end else if (k == 11) begin
        start_v[0] = 1'b0;
      end
      if (k <= 40) begin
        if (pin_v[0] !== exp[(k - 1) / 4] || busy_v[0] !== 1'b1) bad++;
      end else begin
        if (pin_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
      end
    end
    chk("overrun write ignored bad cycles", bad, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
